// File: rtl/pwm_deadtime.sv
// pwm_deadtime: dead-time inserter for a single-ended PWM stream.
// Turns i_pwm into a complementary high/low drive pair. Whenever the active
// side changes, both sides are held off for D clocks (D loaded via
// i_deadtime/i_deadtime_valid). All outputs are registered.
//
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_pwm                  PWM stream, synchronous to i_clk
//   i_deadtime[_valid]     dead-time value and single-cycle load strobe
//   o_high, o_low          high-side / low-side drive (never both 1)
//   o_dead                 high while both sides are off
// Optional feature, macro PWM_DEADTIME_FAULT_EN:
//   i_fault                level fault input, forces the dead state
//   i_fault_clear          clears the fault latch when i_fault is low
//   o_fault                registered fault latch
module pwm_deadtime #(
    parameter int unsigned DEADTIME_WIDTH   = 8,
    parameter int unsigned DEFAULT_DEADTIME = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_pwm,
    input  logic [DEADTIME_WIDTH-1:0] i_deadtime,
    input  logic                      i_deadtime_valid,
`ifdef PWM_DEADTIME_FAULT_EN
    input  logic                      i_fault,
    input  logic                      i_fault_clear,
    output logic                      o_fault,
`endif
    output logic                      o_high,
    output logic                      o_low,
    output logic                      o_dead
);

    localparam int unsigned RST_BAND = (DEFAULT_DEADTIME > 0) ? DEFAULT_DEADTIME : 1;
    localparam logic [DEADTIME_WIDTH-1:0] RST_COUNT    = DEADTIME_WIDTH'(RST_BAND - 1);
    localparam logic [DEADTIME_WIDTH-1:0] RST_DEADTIME = DEADTIME_WIDTH'(DEFAULT_DEADTIME);
    localparam logic [DEADTIME_WIDTH-1:0] ONE          = DEADTIME_WIDTH'(1);

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_HIGH = 2'd1,
        S_DEAD = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [DEADTIME_WIDTH-1:0] count_q, count_d;        // dead-band down-counter
    logic [DEADTIME_WIDTH-1:0] deadtime_q, deadtime_d;  // programmed dead time D
    logic                      high_q, high_d;
    logic                      low_q, low_d;
    logic                      dead_q, dead_d;
`ifdef PWM_DEADTIME_FAULT_EN
    logic                      fault_q, fault_d;
    logic [DEADTIME_WIDTH-1:0] freeze_count;
`endif

    // State, counter, dead-time and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_DEAD;
            count_q    <= RST_COUNT;
            deadtime_q <= RST_DEADTIME;
            high_q     <= 1'b0;
            low_q      <= 1'b0;
            dead_q     <= 1'b1;
`ifdef PWM_DEADTIME_FAULT_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            deadtime_q <= deadtime_d;
            high_q     <= high_d;
            low_q      <= low_d;
            dead_q     <= dead_d;
`ifdef PWM_DEADTIME_FAULT_EN
            fault_q    <= fault_d;
`endif
        end
    end

    // Next-state: entries into the dead band always use the pre-load D
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        deadtime_d = i_deadtime_valid ? i_deadtime : deadtime_q;
`ifdef PWM_DEADTIME_FAULT_EN
        fault_d      = fault_q;
        freeze_count = (deadtime_q == '0) ? '0 : (deadtime_q - ONE);
`endif
        case (state_q)
            S_LOW: begin
                if (i_pwm) begin
                    if (deadtime_q == '0) begin
                        state_d = S_HIGH;
                    end else begin
                        state_d = S_DEAD;
                        count_d = deadtime_q - ONE;
                    end
                end
            end
            S_HIGH: begin
                if (!i_pwm) begin
                    if (deadtime_q == '0) begin
                        state_d = S_LOW;
                    end else begin
                        state_d = S_DEAD;
                        count_d = deadtime_q - ONE;
                    end
                end
            end
            S_DEAD: begin
                // Exit side is whatever i_pwm is at expiry, not latched on entry
                if (count_q != '0) begin
                    count_d = count_q - ONE;
                end else begin
                    state_d = i_pwm ? S_HIGH : S_LOW;
                end
            end
            default: begin
                state_d = S_DEAD;
                count_d = '0;
            end
        endcase
`ifdef PWM_DEADTIME_FAULT_EN
        // Fault overrides everything; while latched, the count stays parked
        // so that a clear is followed by a full dead band
        if (i_fault) begin
            state_d = S_DEAD;
            count_d = freeze_count;
            fault_d = 1'b1;
        end else if (fault_q) begin
            state_d = S_DEAD;
            count_d = freeze_count;
            if (i_fault_clear) begin
                fault_d = 1'b0;
            end
        end
`endif
    end

    // Output decode from the next state so the drive pins are flop outputs
    always_comb begin
        high_d = 1'b0;
        low_d  = 1'b0;
        dead_d = 1'b0;
        case (state_d)
            S_HIGH:  high_d = 1'b1;
            S_LOW:   low_d  = 1'b1;
            default: dead_d = 1'b1;
        endcase
    end

    assign o_high = high_q;
    assign o_low  = low_q;
    assign o_dead = dead_q;
`ifdef PWM_DEADTIME_FAULT_EN
    assign o_fault = fault_q;
`endif

endmodule

// File: tb/tb_pwm_deadtime.sv
// Self-checking bench for pwm_deadtime: a clock-level model of the
// dead-band rules checked every cycle, plus hand-computed edge checks.
module tb_pwm_deadtime;

    localparam int unsigned W   = 8;
    localparam int unsigned DEF = 8;

    logic         i_clk            = 1'b0;
    logic         i_rst_n          = 1'b0;
    logic         i_pwm            = 1'b0;
    logic [W-1:0] i_deadtime       = '0;
    logic         i_deadtime_valid = 1'b0;
    logic         o_high, o_low, o_dead;
`ifdef PWM_DEADTIME_FAULT_EN
    logic         i_fault          = 1'b0;
    logic         i_fault_clear    = 1'b0;
    logic         o_fault;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pwm_deadtime #(
        .DEADTIME_WIDTH   (W),
        .DEFAULT_DEADTIME (DEF)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_pwm            (i_pwm),
        .i_deadtime       (i_deadtime),
        .i_deadtime_valid (i_deadtime_valid),
`ifdef PWM_DEADTIME_FAULT_EN
        .i_fault          (i_fault),
        .i_fault_clear    (i_fault_clear),
        .o_fault          (o_fault),
`endif
        .o_high           (o_high),
        .o_low            (o_low),
        .o_dead           (o_dead)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_left = clocks of dead band still to serve (0 = a side is on),
    // m_side = side that is on (or was last selected), m_d = programmed D.
    int m_left, m_side, m_d, d_old;
    bit m_fault;

    always @(posedge i_clk) begin
        if (!i_rst_n) begin
            m_left  = (DEF > 0) ? DEF : 1;
            m_side  = 0;
            m_d     = DEF;
            m_fault = 1'b0;
        end else begin
            d_old = m_d;
`ifdef PWM_DEADTIME_FAULT_EN
            if (i_fault) begin
                m_fault = 1'b1;
                m_left  = (d_old > 0) ? d_old : 1;
            end else if (m_fault) begin
                if (i_fault_clear) m_fault = 1'b0;
                m_left = (d_old > 0) ? d_old : 1;
            end else
`endif
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_side = int'(i_pwm);
            end else if (int'(i_pwm) != m_side) begin
                if (d_old == 0) m_side = int'(i_pwm);
                else            m_left = d_old;
            end
            if (i_deadtime_valid) m_d = int'(i_deadtime);
        end
        #1;
        check("model_high", int'(o_high), int'(m_left == 0 && m_side == 1));
        check("model_low",  int'(o_low),  int'(m_left == 0 && m_side == 0));
        check("model_dead", int'(o_dead), int'(m_left > 0));
`ifdef PWM_DEADTIME_FAULT_EN
        check("model_fault", int'(o_fault), int'(m_fault));
`endif
        check("no_overlap", int'(o_high & o_low), 0);
    end

    task automatic load_d(input int d);
        @(negedge i_clk);
        i_deadtime       = W'(d);
        i_deadtime_valid = 1'b1;
        @(negedge i_clk);
        i_deadtime_valid = 1'b0;
    endtask

    int low_off, high_seen;

    initial begin
        // Reset release with pwm=0: 8 dead clocks then low side
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (7) @(posedge i_clk);
        #1 check("rst_dead_edge7", int'(o_dead), 1);
        check("rst_low_edge7", int'(o_low), 0);
        @(posedge i_clk);
        #1 check("rst_low_edge8", int'(o_low), 1);
        check("rst_dead_edge8", int'(o_dead), 0);

        // D=3 rising and falling transitions
        load_d(3);
        repeat (2) @(negedge i_clk);
        i_pwm = 1'b1;
        @(posedge i_clk); #1 check("d3_low_off_k", int'(o_low), 0);
        check("d3_dead_k", int'(o_dead), 1);
        repeat (2) @(posedge i_clk);
        #1 check("d3_high_k2", int'(o_high), 0);
        @(posedge i_clk); #1 check("d3_high_k3", int'(o_high), 1);
        repeat (3) @(negedge i_clk);
        i_pwm = 1'b0;
        @(posedge i_clk); #1 check("d3_high_off_k", int'(o_high), 0);
        repeat (2) @(posedge i_clk);
        #1 check("d3_low_k2", int'(o_low), 0);
        @(posedge i_clk); #1 check("d3_low_k3", int'(o_low), 1);

        // D=0: direct swap every 5 clocks
        load_d(0);
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            i_pwm = ~i_pwm;
            @(posedge i_clk);
            #1 check("d0_high_follows", int'(o_high), int'(i_pwm));
            check("d0_dead", int'(o_dead), 0);
            repeat (4) @(negedge i_clk);
        end

        // D=4, 2-clock pulse is swallowed
        load_d(4);
        repeat (2) @(negedge i_clk);
        low_off = 0; high_seen = 0;
        i_pwm = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk); #1;
            if (!o_low) low_off++;
            if (o_high) high_seen++;
            if (i == 1) i_pwm = 1'b0;
        end
        check("swallow_low_off", low_off, 4);
        check("swallow_high_seen", high_seen, 0);

        // D=8 band, D=2 loaded 3 clocks into it
        load_d(8);
        repeat (2) @(negedge i_clk);
        i_pwm = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge i_clk); #1;
            if (i == 2) begin i_deadtime = W'(2); i_deadtime_valid = 1'b1; end
            if (i == 3) i_deadtime_valid = 1'b0;
            if (i == 7) check("ld_band_k7", int'(o_dead), 1);
            if (i == 8) check("ld_high_k8", int'(o_high), 1);
        end
        repeat (2) @(negedge i_clk);
        i_pwm = 1'b0;
        @(posedge i_clk); #1 check("ld_new_k", int'(o_dead), 1);
        @(posedge i_clk); #1 check("ld_new_k1", int'(o_dead), 1);
        @(posedge i_clk); #1 check("ld_new_k2", int'(o_low), 1);

        // Asynchronous reset mid-operation
        repeat (3) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1 check("arst_low", int'(o_low), 0);
        check("arst_high", int'(o_high), 0);
        check("arst_dead", int'(o_dead), 1);
        i_pwm = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (8) @(posedge i_clk);
        #1 check("arst_high_edge8", int'(o_high), 1);

`ifdef PWM_DEADTIME_FAULT_EN
        // Fault during S_HIGH, then clear with D=5
        load_d(5);
        repeat (2) @(negedge i_clk);
        i_fault = 1'b1;
        @(posedge i_clk); #1 check("flt_high", int'(o_high), 0);
        check("flt_low", int'(o_low), 0);
        check("flt_latch", int'(o_fault), 1);
        @(negedge i_clk);
        i_fault = 1'b0;
        repeat (3) @(negedge i_clk);
        i_fault = 1'b1; i_fault_clear = 1'b1;
        @(posedge i_clk); #1 check("flt_wins", int'(o_fault), 1);
        @(negedge i_clk);
        i_fault = 1'b0;
        @(posedge i_clk); #1 check("flt_cleared", int'(o_fault), 0);
        @(negedge i_clk);
        i_fault_clear = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge i_clk); #1;
            if (i == 4) check("flt_dead_c4", int'(o_dead), 1);
            if (i == 5) check("flt_high_c5", int'(o_high), 1);
        end
`endif

        repeat (5) @(negedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime.md
# pwm_deadtime

Dead-time inserter placed directly downstream of the `pwm` generator. It consumes the single-ended `o_pwm` stream and drives a complementary high-side/low-side output pair. Whenever the active side changes, both sides are held off for a programmable number of clocks, which replaces the raw `pwm`/`~pwm` pair on the PMOD pins. The dead-time value is loaded with the same value/valid convention the sequencer uses for `top` and `compare`.

## Interface
- `DEADTIME_WIDTH`, 8: width of the dead-time count.
- `DEFAULT_DEADTIME`, 8: dead time in clocks after reset.
- `i_clk`  in  1: system clock; all logic on the rising edge.
- `i_rst_n`  in  1: reset, asynchronous assert, active-low.
- `i_pwm`  in  1: PWM stream from the `pwm` block, synchronous to `i_clk`.
- `i_deadtime`  in  DEADTIME_WIDTH: new dead time D in clocks.
- `i_deadtime_valid`  in  1: single-cycle load strobe for `i_deadtime`.
- `o_high`  out  1: high-side drive, registered.
- `o_low`  out  1: low-side drive, registered.
- `o_dead`  out  1: high while in the dead band (both sides off), registered.

## Operation
- Registers:
  - `r_deadtime`: DEADTIME_WIDTH bits.
  - `r_count`: DEADTIME_WIDTH bits, down-counter.
  - state, one of three:
    - S_LOW: `o_low`=1, `o_high`=0.
    - S_HIGH: `o_high`=1, `o_low`=0.
    - S_DEAD: both 0, `o_dead`=1.
- Transitions, evaluated at every edge on the sampled `i_pwm`:
  - From S_LOW with `i_pwm`=1, or from S_HIGH with `i_pwm`=0:
    - If `r_deadtime`=0, go directly to the opposite on-state.
    - Otherwise go to S_DEAD with `r_count`=`r_deadtime`-1.
  - In S_DEAD with `r_count`≠0: decrement `r_count`.
  - In S_DEAD with `r_count`=0: go to S_HIGH if `i_pwm`=1, else S_LOW.
- Dead-band target is not latched:
  - The exit side is whatever `i_pwm` is at expiry.
  - A pulse shorter than D is therefore swallowed; the previous side re-enables after the full D cycles.
- `i_pwm` changes while in S_DEAD do not reload or restart `r_count`.
- Dead-time load:
  - `i_deadtime_valid`=1 loads `r_deadtime` at that edge.
  - The new value takes effect from the next entry into S_DEAD.
  - A dead band already in progress is not altered.
  - If a load and an S_DEAD entry occur on the same edge, the entry uses the old `r_deadtime`.
- Invariant: `o_high` & `o_low` is never 1, in any state, including reset.
- Reset values:
  - state = S_DEAD.
  - `r_count` = max(`DEFAULT_DEADTIME`,1)-1.
  - `r_deadtime` = `DEFAULT_DEADTIME`.
  - `o_high`=0, `o_low`=0, `o_dead`=1.
- Reset asserted mid-operation: outputs go to the reset values immediately, without waiting for a clock edge.

## Timing
- Let k be the first edge that samples a new `i_pwm` level.
- Outgoing side:
  - It deasserts at edge k.
  - Latency from the `i_pwm` change is 1 clock.
- Incoming side:
  - With D≥1, it asserts at edge k+D, giving exactly D clocks with both sides off.
  - With D=0, it asserts at edge k, as a direct swap with `o_dead` never asserting.
- After reset release, both sides stay off for max(`DEFAULT_DEADTIME`,1) clocks. The side selected by `i_pwm` then enables.
- Maximum dead band: 2^DEADTIME_WIDTH-1 clocks.

## Configuration
- Macro: `PWM_DEADTIME_FAULT_EN`.
- Defined: adds the following ports:
  - `i_fault` (in, 1): level input, sampled each edge.
  - `i_fault_clear` (in, 1): clear request.
  - `o_fault` (out, 1): registered fault latch; resets to 0.
- Fault behaviour when defined:
  - `i_fault`=1 at an edge forces S_DEAD at that edge, with both sides off and `o_fault`=1. This has priority over every other transition.
  - The block holds S_DEAD with `r_count` frozen at `r_deadtime`-1 (or 0 if D=0) while `o_fault`=1.
  - `i_fault_clear`=1 with `i_fault`=0 clears `o_fault`. The normal dead-band countdown then runs for a full D clocks before enabling the side selected by `i_pwm`.
  - Fault and clear on the same edge: the fault wins.
- Undefined: the three ports do not exist, and the behaviour is exactly as in Operation.

## Test plan
- Reset with `i_pwm`=0 and `DEFAULT_DEADTIME`=8: `o_dead`=1 and both sides off for 8 edges after release. Then `o_low`=1 and `o_dead`=0.
- Load D=3, then step `i_pwm` 0→1 (first sampled at edge k): `o_low` falls at k, `o_high` rises at k+3. For 1→0: `o_high` falls at k', `o_low` rises at k'+3.
- Load D=0 and toggle `i_pwm` every 5 clocks: `o_high`==~`o_low` at every edge with 1-clock latency, and `o_dead` stays 0.
- D=4, 2-clock high pulse while in S_LOW: `o_high` never asserts, `o_low` is off for exactly 4 clocks, then returns to 1.
- D=8 with `i_deadtime`=2 loaded 3 clocks into a dead band: the current band still lasts 8 clocks, and the next transition has a 2-clock band.
- Fault test, with `PWM_DEADTIME_FAULT_EN` defined and D=5:
  - `i_fault` pulse during S_HIGH: both sides off and `o_fault`=1 at the next edge.
  - `i_fault_clear` with `i_fault`=0: 5 clocks dead, then `o_high`=1 when `i_pwm`=1.
- Every scenario asserts that `o_high` & `o_low` never equals 1.
